// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_pkg
// Description : Shared types and constants for the four-requester round-robin
//               arbiter (requester count, index width, FSM state encoding,
//               index-to-one-hot helper).
// Revision    : 1.0  initial release
// ============================================================================
package rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_t;

    typedef logic [IDX_W-1:0] req_idx_t;

    // Decode an encoded requester index into its one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] idx2onehot(input req_idx_t i_idx);
        logic [NUM_REQ-1:0] v;
        v        = '0;
        v[i_idx] = 1'b1;
        return v;
    endfunction

endpackage : rr_arbiter_pkg
`default_nettype wire

// File: rtl/rr_pick_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_4
// Description : Purely combinational rotating-priority scan. Starting at the
//               pointer position and wrapping mod 4, returns the first
//               asserted request bit.
// Ports       : i_req   [3:0] request vector
//               i_ptr   [1:0] highest-priority position for this scan
//               o_sel   [1:0] selected index (equals i_ptr when none found)
//               o_found       1 when any request bit is set
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick_4
    import rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  req_idx_t           i_ptr,
    output req_idx_t           o_sel,
    output logic               o_found
);

    req_idx_t w_cand;

    // Walk from the lowest priority position to the highest so the last
    // hit written is the one closest to the pointer.
    always_comb begin
        o_sel   = i_ptr;
        o_found = 1'b0;
        w_cand  = i_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = i_ptr + req_idx_t'(k);
            if (i_req[w_cand]) begin
                o_sel   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule : rr_pick_4
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : Four-requester round-robin arbiter with grant hold, owner
//               release, optional hold timeout and a mandatory one-cycle gap
//               between successive owners. All outputs are registered.
// Ports       : Clock_In               clock, rising edge active
//               Reset_In               synchronous active-low reset
//               Request_In      [3:0]  per-requester request
//               Release_In      [3:0]  per-requester release (owner bit only)
//               Grant_Out       [3:0]  one-hot grant, zero when idle
//               Grant_Index_Out [1:0]  encoded owner, holds last owner when idle
//               Grant_Valid_Out        1 while a grant is asserted
//               Timeout_Out            one-cycle pulse on a hold-timeout revoke
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter_4
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               Clock_In,
    input  logic               Reset_In,
    input  logic [NUM_REQ-1:0] Request_In,
    input  logic [NUM_REQ-1:0] Release_In,
    output logic [NUM_REQ-1:0] Grant_Out,
    output req_idx_t           Grant_Index_Out,
    output logic               Grant_Valid_Out,
    output logic               Timeout_Out
);

    // Hold counter wide enough for 0..MAX_HOLD, never narrower than one bit.
    localparam int c_CNT_W = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST =
        c_CNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = {c_CNT_W{1'b1}};

    arb_state_t         r_state,   w_state_nxt;
    req_idx_t           r_ptr,     w_ptr_nxt;
    logic [c_CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [NUM_REQ-1:0] r_grant,   w_grant_nxt;
    req_idx_t           r_idx,     w_idx_nxt;
    logic               r_valid,   w_valid_nxt;
    logic               r_timeout, w_timeout_nxt;

    req_idx_t           w_sel;
    logic               w_found;
    logic               w_end_rel;
    logic               w_end_drop;
    logic               w_end_tmo;

    rr_pick_4 u_pick (
        .i_req   (Request_In),
        .i_ptr   (r_ptr),
        .o_sel   (w_sel),
        .o_found (w_found)
    );

    // End conditions for the current owner; only its own bits matter.
    assign w_end_rel  = Release_In[r_idx];
    assign w_end_drop = ~Request_In[r_idx];
    assign w_end_tmo  = (MAX_HOLD != 0) && (r_cnt == c_HOLD_LAST);

    always_ff @(posedge Clock_In) begin
        if (!Reset_In) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = idx2onehot(w_sel);
                    w_idx_nxt   = w_sel;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end

            ST_GRANT: begin
                if (w_end_rel || w_end_drop || w_end_tmo) begin
                    w_state_nxt   = ST_RECOVER;
                    w_grant_nxt   = '0;
                    w_valid_nxt   = 1'b0;
                    w_ptr_nxt     = r_idx + req_idx_t'(1);
                    // A voluntary end on the same edge masks the timeout flag.
                    w_timeout_nxt = w_end_tmo && !w_end_rel && !w_end_drop;
                end else if (r_cnt != c_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            ST_RECOVER: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign Grant_Out       = r_grant;
    assign Grant_Index_Out = r_idx;
    assign Grant_Valid_Out = r_valid;
    assign Timeout_Out     = r_timeout;

endmodule : rr_arbiter_4
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_4
// Description : Self-checking bench for rr_arbiter_4 (MAX_HOLD = 4). A
//               behavioural model tracks owner / pointer / visible-cycle count
//               and queues the expected registered outputs for every edge; an
//               independent monitor pops and compares one entry per cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arbiter_4;

    localparam int c_MAX_HOLD = 4;

    logic       clk;
    logic       Reset_In;
    logic [3:0] Request_In;
    logic [3:0] Release_In;
    logic [3:0] Grant_Out;
    logic [1:0] Grant_Index_Out;
    logic       Grant_Valid_Out;
    logic       Timeout_Out;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model: owner = -1 means nobody holds the resource.
    int   m_owner   = -1;
    int   m_ptr     = 0;
    int   m_last    = 0;
    int   m_visible = 0;
    bit   m_gap     = 0;
    bit   m_tmo     = 0;

    rr_arbiter_4 #(.MAX_HOLD(c_MAX_HOLD)) dut (
        .Clock_In        (clk),
        .Reset_In        (Reset_In),
        .Request_In      (Request_In),
        .Release_In      (Release_In),
        .Grant_Out       (Grant_Out),
        .Grant_Index_Out (Grant_Index_Out),
        .Grant_Valid_Out (Grant_Valid_Out),
        .Timeout_Out     (Timeout_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one rising edge given the inputs seen at that edge.
    task automatic model_edge(input logic [3:0] req, input logic [3:0] rel, input logic rstn);
        exp_t e;
        bit   by_rel, by_drop, by_tmo;
        m_tmo = 0;
        if (!rstn) begin
            m_owner = -1; m_ptr = 0; m_last = 0; m_visible = 0; m_gap = 0;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_owner >= 0) begin
            by_rel  = rel[m_owner];
            by_drop = !req[m_owner];
            by_tmo  = (c_MAX_HOLD != 0) && (m_visible == c_MAX_HOLD);
            if (by_rel || by_drop || by_tmo) begin
                m_tmo   = by_tmo && !by_rel && !by_drop;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_visible++;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
                    m_owner   = (m_ptr + k) % 4;
                    m_last    = m_owner;
                    m_visible = 1;
                end
            end
        end
        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        e.idx   = 2'(m_last);
        e.valid = (m_owner >= 0);
        e.tmo   = m_tmo;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] req, input logic [3:0] rel, input logic rstn);
        @(negedge clk);
        Request_In = req;
        Release_In = rel;
        Reset_In   = rstn;
        model_edge(req, rel, rstn);
    endtask

    // Monitor: every edge presents a fresh registered output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({Grant_Out, Grant_Index_Out, Grant_Valid_Out, Timeout_Out} !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got grant=%b idx=%0d valid=%b tmo=%b, want grant=%b idx=%0d valid=%b tmo=%b",
                             $time, Grant_Out, Grant_Index_Out, Grant_Valid_Out, Timeout_Out,
                             e.grant, e.idx, e.valid, e.tmo);
                end
            end
        end
    end

    initial begin
        logic [3:0] req;
        logic [3:0] rel;
        Reset_In   = 1'b0;
        Request_In = 4'b0000;
        Release_In = 4'b0000;

        // 1: basic grant, release, recover gap, next requester
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0101, 4'b0000, 1'b1);
        step(4'b0101, 4'b0000, 1'b1);
        step(4'b0101, 4'b0001, 1'b1);
        step(4'b0101, 4'b0000, 1'b1);
        step(4'b0101, 4'b0000, 1'b1);
        step(4'b0101, 4'b0100, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // 2: all requesting, each owner releases in its 2nd cycle: 0,1,2,3,0
        step(4'b0000, 4'b0000, 1'b0);
        for (int n = 0; n < 5; n++) begin
            step(4'b1111, 4'b0000, 1'b1);
            step(4'b1111, 4'b0000, 1'b1);
            step(4'b1111, 4'(1 << (n % 4)), 1'b1);
            step(4'b1111, 4'b0000, 1'b1);
        end

        // 3: hold timeout, lone requester re-granted after the gap
        step(4'b0000, 4'b0000, 1'b0);
        for (int n = 0; n < 12; n++) step(4'b0010, 4'b0000, 1'b1);

        // 4: release coincides with timeout; non-owner release ignored
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b1000, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0001, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // 5: reset mid-grant of requester 2, then 1100 picks requester 2
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b0);
        step(4'b1100, 4'b0000, 1'b1);
        step(4'b1100, 4'b0000, 1'b1);
        step(4'b1100, 4'b0100, 1'b1);
        step(4'b1100, 4'b0000, 1'b1);
        step(4'b1100, 4'b0000, 1'b1);

        // 6: owner drops its request without releasing
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Randomised traffic: sticky requests, sparse releases, rare resets
        req = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            rel = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0000;
            step(req, rel, ($urandom_range(99) != 0));
        end

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net: stimulus never waits on the DUT, but never let a run hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_rr_arbiter_4
`default_nettype wire

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource.
- The winner's 2-bit index is published in encoded form, alongside its one-hot form.
- Sits upstream of the team's 2-to-4 decode path: Grant_Index_Out is the encoded select and Grant_Out is its decoded equivalent.
- Grants are held until the owner releases them or a hold timeout expires.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles a single grant may stay asserted before it is forcibly revoked. 0 means unlimited. Legal range 0..255.

Ports:
- Clock_In  input  1  single clock; all state changes on its rising edge.
- Reset_In  input  1  synchronous, active-low reset. When sampled 0 at a rising edge, all state clears.
- Request_In  input  4  one bit per requester; 1 = requesting the resource.
- Release_In  input  4  one bit per requester; 1 = the current owner gives up its grant. Only the bit of the current owner is honoured.
- Grant_Out  output  4  one-hot grant, all zeros when no owner.
- Grant_Index_Out  output  2  encoded index of the owner; holds the last owner's index when idle.
- Grant_Valid_Out  output  1  1 while any grant is asserted. Always equals |Grant_Out.
- Timeout_Out  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- All outputs are registered.
- Reset (Reset_In=0 at an edge) sets:
  - state=IDLE, priority pointer=0, hold count=0;
  - Grant_Out=4'b0000, Grant_Index_Out=2'd0, Grant_Valid_Out=0, Timeout_Out=0.
- Reset mid-grant clears everything on that same edge; no Timeout pulse is produced.
- FSM states: IDLE, GRANT, RECOVER.
- IDLE:
  - If Request_In != 0, select the first asserted bit scanning pointer, pointer+1, ... with mod-4 wrap.
  - On the next edge: Grant_Out=onehot(sel), Grant_Index_Out=sel, hold count=0, state=GRANT.
  - Latency from request sampled to grant visible is 1 cycle.
  - If Request_In == 0, remain in IDLE.
- GRANT, owner = Grant_Index_Out:
  - End conditions: Release_In[owner]=1, OR Request_In[owner]=0, OR (MAX_HOLD!=0 AND hold count == MAX_HOLD-1).
  - On an end condition: the next edge clears Grant_Out and Grant_Valid_Out, sets pointer=(owner+1) mod 4 (index 3 wraps to 0), and goes to RECOVER.
  - Otherwise: hold count increments and state stays GRANT.
  - Net effect: a never-released grant is visible exactly MAX_HOLD cycles.
  - Timeout_Out=1 for the one cycle after the edge that revokes the grant, and only when the timeout was the sole end condition. Release or request-drop coinciding with the timeout takes precedence, so no pulse is produced.
  - Release_In bits of non-owners are ignored in every state.
  - Request_In changes of non-owners do not affect the current grant.
- RECOVER:
  - Exactly one dead cycle with no grant, which guarantees no two owners are ever adjacent without a gap.
  - Then unconditionally return to IDLE; arbitration resumes in IDLE with the updated pointer.
- Invariants:
  - Grant_Out is zero or one-hot.
  - Grant_Out == (1 << Grant_Index_Out) whenever Grant_Valid_Out=1.
  - The hold counter is $clog2(MAX_HOLD+1) bits wide (min 1) and saturates; it never wraps.

Decomposition:
- Package rr_arbiter_pkg holds:
  - NUM_REQ=4, IDX_W=2;
  - typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RECOVER} arb_state_t;
  - typedef logic [IDX_W-1:0] req_idx_t.
- One natural sub-module: rr_pick_4. It is purely combinational.
  - Inputs: 4-bit request, 2-bit pointer.
  - Outputs: 2-bit selected index and a found flag.
  - Function: rotating priority scan.
- The top module holds the FSM, counter, pointer and output registers.

Test Plan:
1. Reset, then Request_In=4'b0101, pointer=0.
   - Grant_Out=4'b0001 and Grant_Index_Out=0 one cycle later.
   - Pulse Release_In=4'b0001: one RECOVER cycle with Grant_Out=0, then Grant_Out=4'b0100, Grant_Index_Out=2.
2. Wrap: all four requesting continuously, each owner releasing after 2 cycles.
   - Grant order is 0,1,2,3,0.
   - After owner 3 releases, the pointer wraps to 0.
3. Timeout with MAX_HOLD=4: Request_In=4'b0010 held, no release.
   - Grant_Out=4'b0010 for exactly 4 cycles.
   - Timeout_Out=1 for one cycle as the grant drops.
   - After RECOVER, requester 1 is re-granted because it is the only requester.
4. Simultaneous: MAX_HOLD=4 with Release_In[owner]=1 on the 4th grant cycle.
   - Grant drops and Timeout_Out stays 0.
   - Release_In=4'b1000 while requester 0 owns the resource has no effect.
5. Reset mid-grant: Reset_In=0 during GRANT of requester 2.
   - Next edge: all outputs zero and pointer=0.
   - With Request_In=4'b1100 after reset, requester 2 is granted.
6. Request drop: the owner deasserts Request_In without releasing.
   - Grant ends on the next edge, followed by the RECOVER gap.
   - Timeout_Out=0.
